// File: rtl/uart_packetizer_pkg.sv
// Shared definitions for uart_packetizer and its uart_tx partner:
// FSM state encodings, default symbol width/header and index sizing helper.
package uart_packetizer_pkg;

    localparam int         DEF_WORD_WIDTH = 8;
    localparam logic [7:0] DEF_HEADER     = 8'hA5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_CSUM = 2'd2
    } state_e;

    // idx must be able to hold PACKET_WORDS itself, not just PACKET_WORDS-1
    function automatic int idx_width(input int words);
        return $clog2(words + 1);
    endfunction

endpackage

// File: rtl/uart_packetizer_if.sv
// Upstream payload handshake plus the uart_tx symbol handshake of uart_packetizer.
interface uart_packetizer_if
    import uart_packetizer_pkg::*;
#(
    parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int PACKET_WORDS = 8
) ();

    logic [WORD_WIDTH*PACKET_WORDS-1:0] data_in;
    logic                               data_valid;
    logic                               data_ready;
    logic [WORD_WIDTH-1:0]              tx_din;
    logic                               tx_start;
    logic                               tx_done;

    modport slave (
        input  data_in, data_valid, tx_done,
        output data_ready, tx_din, tx_start
    );

    modport master (
        output data_in, data_valid, tx_done,
        input  data_ready, tx_din, tx_start
    );

endinterface

// File: rtl/uart_packetizer_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; holds at all-ones.
module uart_packetizer_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/uart_packetizer.sv
// Frames a wide payload as HEADER + PACKET_WORDS symbols (LSW first) for uart_tx.
// Optional trailing XOR checksum symbol: define UART_PACKETIZER_CHECKSUM_EN.
module uart_packetizer
    import uart_packetizer_pkg::*;
#(
    parameter int                    WORD_WIDTH   = DEF_WORD_WIDTH,
    parameter int                    PACKET_WORDS = 8,
    parameter logic [WORD_WIDTH-1:0] HEADER       = WORD_WIDTH'(DEF_HEADER),
    parameter int                    DROP_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_packetizer_if.slave      bus,
    output logic                  busy,
    output logic                  packet_done,
    output logic [DROP_WIDTH-1:0] drop_count
);

    localparam int IDX_W = idx_width(PACKET_WORDS);
    localparam int PAY_W = WORD_WIDTH * PACKET_WORDS;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [PAY_W-1:0]      payload_q, payload_d;
    logic [PAY_W-1:0]      payload_shift;
    logic [WORD_WIDTH-1:0] tx_din_q, tx_din_d, cur_word;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  ready, last_done, drop_inc;

`ifdef UART_PACKETIZER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] csum_q, csum_d, in_xor;

    always_comb begin
        in_xor = '0;
        for (int i = 0; i < PACKET_WORDS; i++) begin
            in_xor = in_xor ^ bus.data_in[i*WORD_WIDTH +: WORD_WIDTH];
        end
    end
`endif

    assign payload_shift = payload_q >> (32'(idx_q) * 32'(WORD_WIDTH));
    assign cur_word      = payload_shift[WORD_WIDTH-1:0];
    assign ready         = (state_q == ST_IDLE);
    assign drop_inc      = bus.data_valid & ~ready;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        payload_d  = payload_q;
        tx_din_d   = tx_din_q;
        tx_start_d = tx_start_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        last_done  = 1'b0;
`ifdef UART_PACKETIZER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // tx_done is deliberately not looked at here: uart_tx is never reset
                if (bus.data_valid) begin
                    payload_d  = bus.data_in;
                    idx_d      = '0;
                    tx_din_d   = HEADER;
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SEND;
`ifdef UART_PACKETIZER_CHECKSUM_EN
                    csum_d     = in_xor;
`endif
                end
            end
            ST_SEND: begin
                if (bus.tx_done) begin
                    if (idx_q < IDX_W'(PACKET_WORDS)) begin
                        tx_din_d = cur_word;
                        idx_d    = idx_q + IDX_W'(1);
                    end else begin
`ifdef UART_PACKETIZER_CHECKSUM_EN
                        tx_din_d = csum_q;
                        state_d  = ST_CSUM;
`else
                        last_done = 1'b1;
`endif
                    end
                end
            end
`ifdef UART_PACKETIZER_CHECKSUM_EN
            ST_CSUM: begin
                if (bus.tx_done) begin
                    last_done = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // tx_start drops with the final tx_done, before uart_tx returns to idle
        if (last_done) begin
            state_d    = ST_IDLE;
            tx_start_d = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tx_din_q   <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tx_din_q   <= tx_din_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        payload_q <= payload_d;
`ifdef UART_PACKETIZER_CHECKSUM_EN
        csum_q    <= csum_d;
`endif
    end

    uart_packetizer_sat_counter #(
        .WIDTH(DROP_WIDTH)
    ) u_drop (
        .clk    (clk),
        .rst    (rst),
        .inc_i  (drop_inc),
        .count_o(drop_count)
    );

    assign bus.data_ready = ready;
    assign bus.tx_din     = tx_din_q;
    assign bus.tx_start   = tx_start_q;
    assign busy           = busy_q;
    assign packet_done    = done_q;

endmodule
